// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller: stall codes,
// reset/stop encodings, exception type constants and the FSM state type.
package pipe_ctrl_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  localparam logic [31:0] ZeroWord             = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET             = 32'h0000_000e;
  localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_0020;

  // One bit per stage, LSB = PC; a stalling stage also holds every earlier stage.
  localparam logic [5:0] STALL_NONE = {6{NoStop}};
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_REFILL
  } state_e;

  function automatic logic [5:0] stall_decode(input logic req_id,
                                              input logic req_ex,
                                              input logic req_mem);
    logic [5:0] code;
    code = STALL_NONE;
    if (req_mem)     code = STALL_MEM;
    else if (req_ex) code = STALL_EX;
    else if (req_id) code = STALL_ID;
    return code;
  endfunction

endpackage

// File: rtl/pipe_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles (saturating) and raises
// a sticky timeout flag once the count reaches STALL_LIMIT.
module pipe_stall_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_active,
  output logic stall_timeout
);

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (!stall_active) begin
      cnt_d = 8'd0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (cnt_d == LIMIT) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall decode, exception flush/redirect sequencing
// with a post-flush refill window, flush counter and stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR  = DEFAULT_HANDLER_ADDR,
  parameter int          REFILL_CYCLES = 2,
  parameter int          STALL_LIMIT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [15:0] exc_count
);

  localparam logic [3:0] REFILL_LOAD = 4'(REFILL_CYCLES);

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [3:0]  refill_q, refill_d;
  logic [15:0] exc_count_q, exc_count_d;

  // Stall is combinational; a pending exception in RUN outranks every request.
  always_comb begin
    stall = STALL_NONE;
    if (rst != RstEnable) begin
      case (state_q)
        ST_RUN: begin
          if (excepttype_i == ZeroWord)
            stall = stall_decode(stallreq_id, stallreq_ex, stallreq_mem);
        end
        ST_REFILL: stall = stall_decode(stallreq_id, stallreq_ex, stallreq_mem);
        default:   stall = STALL_NONE;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_d     = 1'b0;
    new_pc_d    = ZeroWord;
    refill_d    = refill_q;
    exc_count_d = exc_count_q;
    case (state_q)
      ST_RUN: begin
        if (excepttype_i != ZeroWord) begin
          state_d     = ST_FLUSH;
          flush_d     = 1'b1;
          new_pc_d    = (excepttype_i == EXC_ERET) ? cp0_epc_i : HANDLER_ADDR;
          refill_d    = REFILL_LOAD;
          exc_count_d = exc_count_q + 16'd1;
        end
      end
      ST_FLUSH: state_d = ST_REFILL;
      ST_REFILL: begin
        // Exceptions stay masked until the refill window has drained.
        if (refill_q <= 4'd1) begin
          state_d  = ST_RUN;
          refill_d = 4'd0;
        end else begin
          refill_d = refill_q - 4'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= ST_RUN;
      flush_q     <= 1'b0;
      new_pc_q    <= ZeroWord;
      refill_q    <= 4'd0;
      exc_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      new_pc_q    <= new_pc_d;
      refill_q    <= refill_d;
      exc_count_q <= exc_count_d;
    end
  end

  pipe_stall_wdog #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_wdog (
    .clk           (clk),
    .rst           (rst),
    .stall_active  (stall != STALL_NONE),
    .stall_timeout (stall_timeout)
  );

  assign flush     = flush_q;
  assign new_pc    = new_pc_q;
  assign exc_count = exc_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each step drives one cycle of inputs,
// queues the expected outputs and compares them before the next edge.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [15:0] exc_count;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [15:0] exc_count;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  pipe_ctrl #(
    .HANDLER_ADDR  (32'h0000_0020),
    .REFILL_CYCLES (2),
    .STALL_LIMIT   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excepttype_i  (excepttype_i),
    .cp0_epc_i     (cp0_epc_i),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout),
    .exc_count     (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs for that cycle,
  // compare once combinational outputs settle, then advance past the edge.
  task automatic step(input logic r, input logic id, input logic ex, input logic mem,
                      input logic [31:0] exc, input logic [31:0] epc,
                      input logic [5:0] e_stall, input logic e_flush,
                      input logic [31:0] e_pc, input logic [15:0] e_cnt,
                      input logic e_to);
    exp_t e;
    rst          = r;
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excepttype_i = exc;
    cp0_epc_i    = epc;
    exp_q.push_back({e_stall, e_flush, e_pc, e_cnt, e_to});
    #1;
    e = exp_q.pop_front();
    chk($sformatf("s%0d.stall", step_no),   {26'd0, stall},         {26'd0, e.stall});
    chk($sformatf("s%0d.flush", step_no),   {31'd0, flush},         {31'd0, e.flush});
    chk($sformatf("s%0d.new_pc", step_no),  new_pc,                 e.new_pc);
    chk($sformatf("s%0d.exc_cnt", step_no), {16'd0, exc_count},     {16'd0, e.exc_count});
    chk($sformatf("s%0d.timeout", step_no), {31'd0, stall_timeout}, {31'd0, e.timeout});
    chk($sformatf("s%0d.excl", step_no), {31'd0, (flush && (stall != 6'd0))}, 32'd0);
    @(posedge clk);
    #1;
    step_no++;
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    excepttype_i = 32'd0; cp0_epc_i = 32'd0;
    @(posedge clk);
    #1;
    //    rst id ex mem exc           epc           stall      fl pc            cnt to
    // Reset holds stall low even with requests and a pending exception.
    step(1, 1, 1, 1, 32'h8,        32'h0,        6'b000000, 0, 32'h0,        0, 0);
    // Stall decode and priority.
    step(0, 1, 0, 0, 32'h0,        32'h0,        6'b000111, 0, 32'h0,        0, 0);
    step(0, 1, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0,        0, 0);
    step(0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        0, 0);
    step(0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        0, 0);
    // Exception with a stall request: handler redirect, two refill cycles.
    step(0, 0, 1, 0, 32'h8,        32'h0,        6'b000000, 0, 32'h0,        0, 0);
    step(0, 0, 1, 0, 32'h0,        32'h0,        6'b000000, 1, 32'h20,       1, 0);
    step(0, 1, 0, 0, 32'h8,        32'h0,        6'b000111, 0, 32'h0,        1, 0);
    step(0, 0, 0, 0, 32'h8,        32'h0,        6'b000000, 0, 32'h0,        1, 0);
    step(0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        1, 0);
    // ERET redirects to the captured EPC.
    step(0, 0, 0, 0, 32'he,        32'h1234,     6'b000000, 0, 32'h0,        1, 0);
    step(0, 0, 0, 0, 32'h0,        32'h5555,     6'b000000, 1, 32'h1234,     2, 0);
    step(0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        2, 0);
    step(0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        2, 0);
    // Held exception: one flush, masked during refill, second flush after.
    step(1, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        2, 0);
    step(0, 0, 0, 0, 32'h8,        32'h0,        6'b000000, 0, 32'h0,        0, 0);
    step(0, 0, 0, 0, 32'h8,        32'h0,        6'b000000, 1, 32'h20,       1, 0);
    step(0, 0, 0, 0, 32'h8,        32'h0,        6'b000000, 0, 32'h0,        1, 0);
    step(0, 0, 0, 0, 32'h8,        32'h0,        6'b000000, 0, 32'h0,        1, 0);
    step(0, 0, 0, 0, 32'h8,        32'h0,        6'b000000, 0, 32'h0,        1, 0);
    step(0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 1, 32'h20,       2, 0);
    step(0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        2, 0);
    step(0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        2, 0);
    // Watchdog: four stalled cycles trip the sticky flag; stall is unaffected.
    step(0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        2, 0);
    step(0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        2, 0);
    step(0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        2, 0);
    step(0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        2, 0);
    step(0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        2, 1);
    step(0, 0, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0,        2, 1);
    step(0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        2, 1);
    step(1, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        2, 1);
    step(0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        0, 0);
    // Reset during FLUSH aborts the sequence; next exception is taken at once.
    step(0, 0, 0, 0, 32'h8,        32'h0,        6'b000000, 0, 32'h0,        0, 0);
    step(1, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 1, 32'h20,       1, 0);
    step(0, 0, 0, 0, 32'h8,        32'h0,        6'b000000, 0, 32'h0,        0, 0);
    step(0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 1, 32'h20,       1, 0);
    step(0, 1, 0, 0, 32'h0,        32'h0,        6'b000111, 0, 32'h0,        1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

endmodule
